// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the core stage controller
package core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    WB    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/core_stage_ctrl_if.sv
// rtl/core_stage_ctrl_if.sv - stage valid/ready handshake bundle between controller and pipeline stages
interface core_stage_ctrl_if;

  logic fetch_stage_valid;
  logic fetch_stage_ready;
  logic exec_stage_valid;
  logic exec_stage_ready;
  logic mem_op;
  logic mem_stage_valid;
  logic mem_stage_ready;
  logic wb_stage_valid;

  modport master (
    output fetch_stage_valid,
    input  fetch_stage_ready,
    output exec_stage_valid,
    input  exec_stage_ready,
    input  mem_op,
    output mem_stage_valid,
    input  mem_stage_ready,
    output wb_stage_valid
  );

  modport slave (
    input  fetch_stage_valid,
    output fetch_stage_ready,
    input  exec_stage_valid,
    output exec_stage_ready,
    output mem_op,
    input  mem_stage_valid,
    output mem_stage_ready,
    input  wb_stage_valid
  );

endinterface

// File: rtl/core_stage_ctrl.sv
// rtl/core_stage_ctrl.sv - FETCH/EXEC/MEM/WB sequencing FSM with retired-instruction counter
module core_stage_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  core_stage_ctrl_if.master   stage,
  output logic                instr_retired,
  output logic [CNT_W-1:0]    retire_count,
  output ctrl_state_e         ctrl_state
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_retire_count;

  // Each state only listens to its own ready; mem_op matters only on the EXEC handoff.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: if (stage.fetch_stage_ready) w_state_nxt = ST_EXEC;
      ST_EXEC:  if (stage.exec_stage_ready)  w_state_nxt = stage.mem_op ? ST_MEM : ST_WB;
      ST_MEM:   if (stage.mem_stage_ready)   w_state_nxt = ST_WB;
      default:                               w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_FETCH;
      r_retire_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_WB) begin
        r_retire_count <= r_retire_count + CNT_W'(1);
      end
    end
  end

  // Valids are pure state decodes, masked while reset is held.
  assign stage.fetch_stage_valid = !rst && (r_state == ST_FETCH);
  assign stage.exec_stage_valid  = !rst && (r_state == ST_EXEC);
  assign stage.mem_stage_valid   = !rst && (r_state == ST_MEM);
  assign stage.wb_stage_valid    = !rst && (r_state == ST_WB);
  assign instr_retired           = stage.wb_stage_valid;
  assign retire_count            = r_retire_count;
  assign ctrl_state              = ctrl_state_e'(r_state);

endmodule

// File: tb/tb_core_stage_ctrl.sv
// tb/tb_core_stage_ctrl.sv - directed self-checking bench for core_stage_ctrl
module tb_core_stage_ctrl;
  import core_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_retired;
  logic [CNT_W-1:0] retire_count;
  ctrl_state_e      ctrl_state;

  core_stage_ctrl_if u_if ();

  core_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stage        (u_if),
    .instr_retired(instr_retired),
    .retire_count (retire_count),
    .ctrl_state   (ctrl_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: which stage the instruction is in (0..3) and how many instructions have retired.
  int m_stage = 0;
  int m_retired = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_stage   = 0;
      m_retired = 0;
    end else begin
      case (m_stage)
        0: if (u_if.fetch_stage_ready) m_stage = 1;
        1: if (u_if.exec_stage_ready)  m_stage = u_if.mem_op ? 2 : 3;
        2: if (u_if.mem_stage_ready)   m_stage = 3;
        default: begin
          m_stage   = 0;
          m_retired = m_retired + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_fetch_valid", 64'(u_if.fetch_stage_valid), 64'(!rst && m_stage == 0));
      chk("cmp_exec_valid",  64'(u_if.exec_stage_valid),  64'(!rst && m_stage == 1));
      chk("cmp_mem_valid",   64'(u_if.mem_stage_valid),   64'(!rst && m_stage == 2));
      chk("cmp_wb_valid",    64'(u_if.wb_stage_valid),    64'(!rst && m_stage == 3));
      chk("cmp_retired",     64'(instr_retired),          64'(!rst && m_stage == 3));
      chk("cmp_count",       64'(retire_count),           64'(m_retired % 256));
      chk("cmp_state",       64'(ctrl_state),             64'(m_stage));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire_alu();
    u_if.fetch_stage_ready = 1'b1;
    step();
    u_if.fetch_stage_ready = 1'b0;
    u_if.exec_stage_ready  = 1'b1;
    u_if.mem_op            = 1'b0;
    step();
    u_if.exec_stage_ready  = 1'b0;
    step();
  endtask

  initial begin
    rst                    = 1'b1;
    u_if.fetch_stage_ready = 1'b0;
    u_if.exec_stage_ready  = 1'b0;
    u_if.mem_op            = 1'b0;
    u_if.mem_stage_ready   = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_fetch_masked", 64'(u_if.fetch_stage_valid), 64'd0);
    chk("rst_wb_masked",    64'(u_if.wb_stage_valid),    64'd0);
    chk("rst_count",        64'(retire_count),           64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_fetch", 64'(u_if.fetch_stage_valid), 64'd1);

    // ALU instruction: FETCH, EXEC, WB over three cycles
    u_if.fetch_stage_ready = 1'b1;
    step();
    u_if.fetch_stage_ready = 1'b0;
    chk("alu_c1_exec", 64'(u_if.exec_stage_valid), 64'd1);
    u_if.exec_stage_ready = 1'b1;
    step();
    u_if.exec_stage_ready = 1'b0;
    chk("alu_c2_wb",      64'(u_if.wb_stage_valid), 64'd1);
    chk("alu_c2_retired", 64'(instr_retired),       64'd1);
    chk("alu_c2_count",   64'(retire_count),        64'd0);
    step();
    chk("alu_c3_fetch", 64'(u_if.fetch_stage_valid), 64'd1);
    chk("alu_c3_wb",    64'(u_if.wb_stage_valid),    64'd0);
    chk("alu_count",    64'(retire_count),           64'd1);

    // Load with MEM ready on the fourth MEM cycle
    u_if.fetch_stage_ready = 1'b1;
    step();
    u_if.fetch_stage_ready = 1'b0;
    u_if.exec_stage_ready  = 1'b1;
    u_if.mem_op            = 1'b1;
    step();
    u_if.exec_stage_ready  = 1'b0;
    u_if.mem_op            = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("load_mem_valid", 64'(u_if.mem_stage_valid), 64'd1);
      if (i == 3) u_if.mem_stage_ready = 1'b1;
      step();
    end
    u_if.mem_stage_ready = 1'b0;
    chk("load_wb",    64'(u_if.wb_stage_valid), 64'd1);
    step();
    chk("load_fetch", 64'(u_if.fetch_stage_valid), 64'd1);
    chk("load_count", 64'(retire_count),           64'd2);

    // Stray readies in FETCH must not move the FSM
    u_if.exec_stage_ready = 1'b1;
    u_if.mem_stage_ready  = 1'b1;
    u_if.mem_op           = 1'b1;
    repeat (3) step();
    chk("stray_fetch_hold", 64'(ctrl_state), 64'(FETCH));
    u_if.exec_stage_ready  = 1'b0;
    u_if.fetch_stage_ready = 1'b1;
    step();
    u_if.fetch_stage_ready = 1'b0;

    // ECALL hang with stray MEM ready and mem_op
    for (int i = 0; i < 100; i++) step();
    chk("ecall_exec_valid", 64'(u_if.exec_stage_valid), 64'd1);
    chk("ecall_count",      64'(retire_count),          64'd2);
    u_if.mem_stage_ready  = 1'b0;
    u_if.mem_op           = 1'b0;
    u_if.exec_stage_ready = 1'b1;
    step();
    u_if.exec_stage_ready = 1'b0;
    chk("ecall_release_wb", 64'(u_if.wb_stage_valid), 64'd1);
    step();
    chk("ecall_count_after", 64'(retire_count), 64'd3);

    // Reset pulse during MEM abandons the load
    u_if.fetch_stage_ready = 1'b1;
    step();
    u_if.fetch_stage_ready = 1'b0;
    u_if.exec_stage_ready  = 1'b1;
    u_if.mem_op            = 1'b1;
    step();
    u_if.exec_stage_ready  = 1'b0;
    u_if.mem_op            = 1'b0;
    step();
    chk("mem_before_rst", 64'(u_if.mem_stage_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mem_masked_rst", 64'(u_if.mem_stage_valid), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 64'(ctrl_state),             64'(FETCH));
    chk("mid_rst_count", 64'(retire_count),           64'd0);
    chk("mid_rst_fetch", 64'(u_if.fetch_stage_valid), 64'd1);
    chk("mid_rst_wb",    64'(u_if.wb_stage_valid),    64'd0);

    // Counter wrap at 8 bits
    for (int i = 0; i < 255; i++) retire_alu();
    chk("wrap_ff", 64'(retire_count), 64'hFF);
    retire_alu();
    chk("wrap_00", 64'(retire_count), 64'h00);

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
